button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Four-channel button front end: synchronize, debounce and turn presses into prioritized one-clock move pulses.
// Optional auto-repeat of held buttons is built when BUTTON_REPEAT_EN is defined.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_n,
    output logic [3:0] level,
    output logic [3:0] press,
    output logic       up_n,
    output logic       down_n,
    output logic       left_n,
    output logic       right_n
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic [3:0] synced;
    logic [3:0] level_q, level_d;
    logic [3:0] cand;
    logic [3:0] press_q, press_d;
    logic [3:0] move_n_q, move_n_d;

    // Repeat timing only matters with repeat built in; this keeps both parameters referenced.
    if (REPEAT_DELAY < REPEAT_PERIOD) begin : g_repeat_shorter_than_period
    end

    always_comb begin
        sync1_d = btn_n;
        sync2_d = sync1_q;
    end

    assign synced = ~sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
        logic [CW-1:0] cnt_q, cnt_d;
        logic          lvl_q, lvl_d;

        // The level flips on the edge after the counter has sat at its maximum.
        always_comb begin
            cnt_d = '0;
            lvl_d = lvl_q;
            if (synced[gi] != lvl_q) begin
                if (cnt_q >= CNT_MAX) begin
                    lvl_d = synced[gi];
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                lvl_q <= lvl_d;
            end
        end

        assign level_q[gi] = lvl_q;
        assign level_d[gi] = lvl_d;

`ifdef BUTTON_REPEAT_EN
        localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RW = $clog2(RPT_MAX + 1);
        localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
        localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

        logic [RW-1:0] rpt_q, rpt_d;
        logic          armed_q, armed_d;
        logic          fire;

        // armed selects the shorter period once the first repeat has fired.
        always_comb begin
            rpt_d   = '0;
            armed_d = 1'b0;
            fire    = 1'b0;
            if (lvl_q && lvl_d) begin
                armed_d = armed_q;
                if (rpt_q >= (armed_q ? PER_LAST : DLY_LAST)) begin
                    fire    = 1'b1;
                    armed_d = 1'b1;
                end else begin
                    rpt_d = rpt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                rpt_q   <= '0;
                armed_q <= 1'b0;
            end else begin
                rpt_q   <= rpt_d;
                armed_q <= armed_d;
            end
        end

        assign cand[gi] = (lvl_d & ~lvl_q) | fire;
`else
        assign cand[gi] = lvl_d & ~lvl_q;
`endif
    end

    // Fixed priority up > down > right > left; losing candidates are dropped.
    always_comb begin
        press_d = 4'b0000;
        if (cand[0])      press_d = 4'b0001;
        else if (cand[1]) press_d = 4'b0010;
        else if (cand[3]) press_d = 4'b1000;
        else if (cand[2]) press_d = 4'b0100;
        move_n_d = ~press_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            press_q  <= 4'b0000;
            move_n_q <= 4'hF;
        end else begin
            press_q  <= press_d;
            move_n_q <= move_n_d;
        end
    end

    assign level   = level_q;
    assign press   = press_q;
    assign up_n    = move_n_q[0];
    assign down_n  = move_n_q[1];
    assign left_n  = move_n_q[2];
    assign right_n = move_n_q[3];

endmodule
